falling_sand_engine: RTL and testbench
======================================

# falling_sand_engine

Parametrised cellular-automaton update engine for the falling-sand game. On each start pulse (one per frame, driven from the top level at vertical blanking) it makes one in-place bottom-up pass over the game RAM, moving every sand cell down, down-left or down-right into empty space. It optionally spawns one grain in the top row at the end of the pass. It is the game's only RAM writer; display readout uses the RAM's other read port.

## Interface
- COLUMNS, 640, grid width in cells (≥2)
- ROWS, 480, grid height in cells (≥2)
- CELL_WIDTH, 1, bits per cell; 0 = empty, 1 = sand, any other value = static wall
- ADDR_WIDTH, $clog2(COLUMNS*ROWS), RAM address width
- clk_i  in  1  single clock
- reset_ni  in  1  synchronous, active-low reset
- start_i  in  1  begin a pass; sampled only in IDLE
- spawn_en_i  in  1  request a grain spawn; sampled together with start_i
- spawn_x_i  in  $clog2(COLUMNS)  spawn column; sampled with start_i
- mem_rd_addr_o  out  ADDR_WIDTH  RAM read address
- mem_rd_data_i  in  CELL_WIDTH  RAM read data, valid exactly 1 cycle after the address
- mem_wr_en_o  out  1  RAM write strobe
- mem_wr_addr_o  out  ADDR_WIDTH  RAM write address
- mem_wr_data_o  out  CELL_WIDTH  RAM write data
- busy_o  out  1  high whenever state ≠ IDLE
- done_o  out  1  one-cycle pulse at end of pass

## Operation
- Address = y*COLUMNS + x. Keep it incrementally: ±1 per column step, −COLUMNS per row step, below = addr + COLUMNS. No multiplier.
- Scan order: y from ROWS−2 down to 0, x from 0 up to COLUMNS−1. Row ROWS−1 is never a source.
- States: IDLE, RD_CELL, CHK_CELL, RD_B, CHK_B, RD_BL, CHK_BL, RD_BR, CHK_BR, WR_DST, WR_SRC, SPAWN_RD, SPAWN_CHK, SPAWN_WR, DONE.
- IDLE → RD_CELL on start_i. Latch spawn_en_i and spawn_x_i at this point.
- CHK_CELL, cell ≠ sand: advance to the next cell's RD_CELL. After the last cell, go to SPAWN_RD if a spawn was latched, else DONE.
- CHK_CELL, cell = sand: go to RD_B.
- CHK_B: if below is empty, dst = below and go to WR_DST. Otherwise go to RD_BL if x>0, else RD_BR.
- CHK_BL: if empty, dst = below-left. Otherwise go to RD_BR if x<COLUMNS−1, else advance.
- CHK_BR: if empty, dst = below-right. Otherwise advance.
- WR_DST writes sand to dst. WR_SRC writes empty to the source, then advances.
- Spawn: if spawn_x_i ≥ COLUMNS, skip straight to DONE. Otherwise read (spawn_x,0); if empty, write sand in SPAWN_WR; then DONE.
- DONE → IDLE.
- A grain moves at most one row per pass. Cells already written are never re-read in the same pass.
- Outputs are undefined-free: mem_wr_addr_o and mem_wr_data_o hold 0 when mem_wr_en_o = 0.

## Timing
- Reset: state IDLE; all outputs 0, including mem_wr_en_o. Reset mid-pass aborts on the next edge with no further writes; RAM contents stay partially updated.
- busy_o rises on the edge that samples start_i.
- Per-cell cost:
  - non-sand cell: 2 cycles
  - straight fall: 6 cycles
  - fall after 1 diagonal check: 8 cycles
  - fall after 2 diagonal checks: 10 cycles
  - fully blocked: 8 cycles at x=0 or x=COLUMNS−1, 10 cycles otherwise
- Spawn adds 2 cycles, or 3 if the write happens.
- Empty grid, no spawn: busy_o is high for 2*(ROWS−1)*COLUMNS + 1 cycles. done_o is high in the final (DONE) cycle, coincident with busy_o.
- start_i while busy is ignored, including during DONE.
- At most one of read or write is issued per cycle.

## Structure
- Shared package sand_pkg: the state enum, and the constants CELL_EMPTY and CELL_SAND sized by CELL_WIDTH through a parametrised localparam in the engine.
- Sub-module sand_scan_counter: x/y/address counters with step, first and last flags.
- Parameters propagate from the top level. The top level replaces its constant write-disable with this engine's write port.

## Test plan
(COLUMNS=4, ROWS=4, CELL_WIDTH=2; RAM model with 1-cycle read latency)
- Empty grid, start_i pulse, no spawn → no writes; done_o exactly 25 cycles after start.
- Single sand at (1,0), 3 passes → at (1,1), then (1,2), then (1,3); a 4th pass leaves it at (1,3).
- Sand at (1,2), sand below at (1,3) → moves to (0,3); writes (0,3)=1 then (1,2)=0 on consecutive cycles.
- Sand at (0,2) with (0,3) sand and (1,3) = wall (2) → no move. Checks below and below-right only; 8 cycles for that cell.
- Spawn with spawn_x_i=2, grid empty → (2,0)=1 after pass. Repeat with spawn_x_i=5 → no write.
- reset_ni low during WR_DST → mem_wr_en_o low on the next cycle; busy_o=0; a subsequent start_i begins a clean pass.

Source files
------------

// File: rtl/sand_pkg.sv
// Shared definitions for the falling-sand update engine: FSM states and cell encodings.
package sand_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_CELL,
    CHK_CELL,
    RD_B,
    CHK_B,
    RD_BL,
    CHK_BL,
    RD_BR,
    CHK_BR,
    WR_DST,
    WR_SRC,
    SPAWN_RD,
    SPAWN_CHK,
    SPAWN_WR,
    DONE
  } state_t;

  // Unsized cell codes; the engine narrows them to CELL_WIDTH.
  localparam int CELL_EMPTY_VAL = 0;
  localparam int CELL_SAND_VAL  = 1;

endpackage

// File: rtl/sand_scan_counter.sv
// Bottom-up raster counter: tracks x, y and the linear address incrementally (no multiplier).
module sand_scan_counter #(
  parameter int COLUMNS    = 640,
  parameter int ROWS       = 480,
  parameter int ADDR_WIDTH = $clog2(COLUMNS * ROWS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  at_left,
  output logic                  at_right,
  output logic                  last
);

  localparam int XW = $clog2(COLUMNS);
  localparam int YW = $clog2(ROWS);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'((ROWS - 2) * COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  // From the end of row y back to the start of row y-1.
  localparam logic [ADDR_WIDTH-1:0] ROW_BACK   = ADDR_WIDTH'(2 * COLUMNS - 1);

  logic [XW-1:0]         x_reg;
  logic [YW-1:0]         y_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;

  assign at_left   = (x_reg == '0);
  assign at_right  = (x_reg == XW'(COLUMNS - 1));
  assign last      = at_right && (y_reg == '0);
  assign addr      = addr_reg;
  assign next_addr = at_right ? (addr_reg - ROW_BACK) : (addr_reg + ADDR_ONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_reg    <= '0;
      y_reg    <= '0;
      addr_reg <= '0;
    end else if (init) begin
      x_reg    <= '0;
      y_reg    <= YW'(ROWS - 2);
      addr_reg <= FIRST_ADDR;
    end else if (step) begin
      if (at_right) begin
        x_reg <= '0;
        y_reg <= y_reg - YW'(1);
      end else begin
        x_reg <= x_reg + XW'(1);
      end
      addr_reg <= next_addr;
    end
  end

endmodule

// File: rtl/falling_sand_engine.sv
// One bottom-up in-place pass over the game RAM per start pulse, moving sand down or diagonally,
// with an optional single-grain spawn in the top row once the pass finishes.
module falling_sand_engine
  import sand_pkg::*;
#(
  parameter int COLUMNS    = 640,
  parameter int ROWS       = 480,
  parameter int CELL_WIDTH = 1,
  parameter int ADDR_WIDTH = $clog2(COLUMNS * ROWS)
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          start_i,
  input  logic                          spawn_en_i,
  // One extra bit so an out-of-range column is representable when COLUMNS is a power of two.
  input  logic [$clog2(COLUMNS+1)-1:0]  spawn_x_i,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr_o,
  input  logic [CELL_WIDTH-1:0]         mem_rd_data_i,
  output logic                          mem_wr_en_o,
  output logic [ADDR_WIDTH-1:0]         mem_wr_addr_o,
  output logic [CELL_WIDTH-1:0]         mem_wr_data_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int SPAWN_XW = $clog2(COLUMNS + 1);
  localparam logic [CELL_WIDTH-1:0] CELL_EMPTY = CELL_WIDTH'(CELL_EMPTY_VAL);
  localparam logic [CELL_WIDTH-1:0] CELL_SAND  = CELL_WIDTH'(CELL_SAND_VAL);
  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'((ROWS - 2) * COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

  state_t                state_reg;
  logic                  spawn_en_reg;
  logic [SPAWN_XW-1:0]   spawn_x_reg;
  logic                  move_reg;

  logic                  scan_init;
  logic                  scan_step;
  logic                  scan_last;
  logic                  scan_at_left;
  logic                  scan_at_right;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic [ADDR_WIDTH-1:0] scan_next_addr;

  logic [ADDR_WIDTH-1:0] below_addr;
  logic [ADDR_WIDTH-1:0] below_left_addr;
  logic [ADDR_WIDTH-1:0] below_right_addr;
  logic [ADDR_WIDTH-1:0] spawn_addr;
  logic                  cell_is_sand;
  logic                  cell_is_empty;

  state_t                adv_state;
  logic [ADDR_WIDTH-1:0] adv_rd_addr;
  logic                  adv_done;

  sand_scan_counter #(
    .COLUMNS    (COLUMNS),
    .ROWS       (ROWS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scan (
    .clk       (clk_i),
    .reset_n   (reset_ni),
    .init      (scan_init),
    .step      (scan_step),
    .addr      (scan_addr),
    .next_addr (scan_next_addr),
    .at_left   (scan_at_left),
    .at_right  (scan_at_right),
    .last      (scan_last)
  );

  assign below_addr       = scan_addr + ROW_STRIDE;
  assign below_left_addr  = below_addr - ADDR_ONE;
  assign below_right_addr = below_addr + ADDR_ONE;
  assign spawn_addr       = ADDR_WIDTH'(spawn_x_reg);
  assign cell_is_sand     = (mem_rd_data_i == CELL_SAND);
  assign cell_is_empty    = (mem_rd_data_i == CELL_EMPTY);

  assign scan_init = (state_reg == IDLE) && start_i;
  assign scan_step = ((state_reg == CHK_CELL) && !cell_is_sand) || (state_reg == WR_SRC);

  // Where the FSM goes once the current cell is finished.
  always_comb begin
    adv_state   = RD_CELL;
    adv_rd_addr = scan_next_addr;
    adv_done    = 1'b0;
    if (scan_last) begin
      if (spawn_en_reg && (spawn_x_reg < SPAWN_XW'(COLUMNS))) begin
        adv_state   = SPAWN_RD;
        adv_rd_addr = spawn_addr;
      end else begin
        adv_state = DONE;
        adv_done  = 1'b1;
      end
    end
  end

  // A blocked grain still spends the two write slots (with writes suppressed) so that
  // every sand cell has the same cost as if it had fallen after the same checks.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_reg     <= IDLE;
      spawn_en_reg  <= 1'b0;
      spawn_x_reg   <= '0;
      move_reg      <= 1'b0;
      mem_rd_addr_o <= '0;
      mem_wr_en_o   <= 1'b0;
      mem_wr_addr_o <= '0;
      mem_wr_data_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      mem_wr_en_o   <= 1'b0;
      mem_wr_addr_o <= '0;
      mem_wr_data_o <= '0;
      done_o        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            state_reg     <= RD_CELL;
            busy_o        <= 1'b1;
            spawn_en_reg  <= spawn_en_i;
            spawn_x_reg   <= spawn_x_i;
            mem_rd_addr_o <= FIRST_ADDR;
          end
        end
        RD_CELL: state_reg <= CHK_CELL;
        CHK_CELL: begin
          if (cell_is_sand) begin
            state_reg     <= RD_B;
            mem_rd_addr_o <= below_addr;
          end else begin
            state_reg     <= adv_state;
            mem_rd_addr_o <= adv_rd_addr;
            done_o        <= adv_done;
          end
        end
        RD_B: state_reg <= CHK_B;
        CHK_B: begin
          if (cell_is_empty) begin
            state_reg     <= WR_DST;
            move_reg      <= 1'b1;
            mem_wr_en_o   <= 1'b1;
            mem_wr_addr_o <= below_addr;
            mem_wr_data_o <= CELL_SAND;
          end else if (!scan_at_left) begin
            state_reg     <= RD_BL;
            mem_rd_addr_o <= below_left_addr;
          end else begin
            state_reg     <= RD_BR;
            mem_rd_addr_o <= below_right_addr;
          end
        end
        RD_BL: state_reg <= CHK_BL;
        CHK_BL: begin
          if (cell_is_empty) begin
            state_reg     <= WR_DST;
            move_reg      <= 1'b1;
            mem_wr_en_o   <= 1'b1;
            mem_wr_addr_o <= below_left_addr;
            mem_wr_data_o <= CELL_SAND;
          end else if (!scan_at_right) begin
            state_reg     <= RD_BR;
            mem_rd_addr_o <= below_right_addr;
          end else begin
            state_reg <= WR_DST;
            move_reg  <= 1'b0;
          end
        end
        RD_BR: state_reg <= CHK_BR;
        CHK_BR: begin
          state_reg <= WR_DST;
          if (cell_is_empty) begin
            move_reg      <= 1'b1;
            mem_wr_en_o   <= 1'b1;
            mem_wr_addr_o <= below_right_addr;
            mem_wr_data_o <= CELL_SAND;
          end else begin
            move_reg <= 1'b0;
          end
        end
        WR_DST: begin
          state_reg <= WR_SRC;
          if (move_reg) begin
            mem_wr_en_o   <= 1'b1;
            mem_wr_addr_o <= scan_addr;
            mem_wr_data_o <= CELL_EMPTY;
          end
        end
        WR_SRC: begin
          state_reg     <= adv_state;
          mem_rd_addr_o <= adv_rd_addr;
          done_o        <= adv_done;
        end
        SPAWN_RD: state_reg <= SPAWN_CHK;
        SPAWN_CHK: begin
          if (cell_is_empty) begin
            state_reg     <= SPAWN_WR;
            mem_wr_en_o   <= 1'b1;
            mem_wr_addr_o <= spawn_addr;
            mem_wr_data_o <= CELL_SAND;
          end else begin
            state_reg <= DONE;
            done_o    <= 1'b1;
          end
        end
        SPAWN_WR: begin
          state_reg <= DONE;
          done_o    <= 1'b1;
        end
        DONE: begin
          state_reg <= IDLE;
          busy_o    <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_falling_sand_engine.sv
// Scoreboard bench for falling_sand_engine on a 4x4 grid with a 1-cycle-latency RAM model.
module tb_falling_sand_engine;

  localparam int COLUMNS    = 4;
  localparam int ROWS       = 4;
  localparam int CELL_WIDTH = 2;
  localparam int ADDR_WIDTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset_ni;
  logic                  start_i;
  logic                  spawn_en_i;
  logic [2:0]            spawn_x_i;
  logic [ADDR_WIDTH-1:0] mem_rd_addr_o;
  logic [CELL_WIDTH-1:0] mem_rd_data_i;
  logic                  mem_wr_en_o;
  logic [ADDR_WIDTH-1:0] mem_wr_addr_o;
  logic [CELL_WIDTH-1:0] mem_wr_data_o;
  logic                  busy_o;
  logic                  done_o;

  falling_sand_engine #(
    .COLUMNS    (COLUMNS),
    .ROWS       (ROWS),
    .CELL_WIDTH (CELL_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_ni),
    .start_i       (start_i),
    .spawn_en_i    (spawn_en_i),
    .spawn_x_i     (spawn_x_i),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_rd_data_i (mem_rd_data_i),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_wr_addr_o (mem_wr_addr_o),
    .mem_wr_data_o (mem_wr_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  // Game RAM model with a bench-side load port used only while the engine is idle.
  logic [CELL_WIDTH-1:0] ram [16];
  logic                  load_en;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [CELL_WIDTH-1:0] load_data;

  always @(posedge clk) begin
    mem_rd_data_i <= ram[mem_rd_addr_o];
    if (mem_wr_en_o) ram[mem_wr_addr_o] <= mem_wr_data_o;
    else if (load_en) ram[load_addr] <= load_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int start_cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit   is_done;
    int   rel;
    int   addr;
    int   data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_wr(input int rel, input int addr, input int data);
    exp_t e;
    e.is_done = 1'b0; e.rel = rel; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int rel);
    exp_t e;
    e.is_done = 1'b1; e.rel = rel; e.addr = 0; e.data = 0;
    exp_q.push_back(e);
  endtask

  // Monitor: every write or done pulse pops one expected transaction.
  always @(negedge clk) begin
    exp_t e;
    int   rel;
    rel = cyc - start_cyc;
    if (mem_wr_en_o || done_o) begin
      if (exp_q.size() == 0) begin
        check(mem_wr_en_o ? "unexpected_write" : "unexpected_done", rel, -1);
      end else begin
        e = exp_q.pop_front();
        if (e.is_done) begin
          $display("done rel=%0d busy=%0d", rel, busy_o);
          check("done_pulse", int'(done_o), 1);
          check("done_cycle", rel, e.rel);
          check("busy_at_done", int'(busy_o), 1);
        end else begin
          $display("wr   rel=%0d addr=%0d data=%0d", rel, mem_wr_addr_o, mem_wr_data_o);
          check("wr_strobe", int'(mem_wr_en_o), 1);
          check("wr_cycle", rel, e.rel);
          check("wr_addr", int'(mem_wr_addr_o), e.addr);
          check("wr_data", int'(mem_wr_data_o), e.data);
        end
      end
    end
    if (!mem_wr_en_o && (mem_wr_addr_o != '0 || mem_wr_data_o != '0))
      check("idle_wr_bus", int'({mem_wr_addr_o, mem_wr_data_o}), 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int x, input int y, input int v);
    load_en   = 1'b1;
    load_addr = ADDR_WIDTH'(y * COLUMNS + x);
    load_data = CELL_WIDTH'(v);
    tick();
    load_en = 1'b0;
  endtask

  task automatic clear_grid();
    for (int a = 0; a < 16; a++) load(a % COLUMNS, a / COLUMNS, 0);
  endtask

  task automatic pulse_start(input bit en, input int x);
    start_i    = 1'b1;
    spawn_en_i = en;
    spawn_x_i  = 3'(x);
    start_cyc  = cyc;
    tick();
    check("busy_rise", int'(busy_o), 1);
    start_i    = 1'b0;
    spawn_en_i = 1'b0;
    spawn_x_i  = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      tick();
      n++;
    end
    if (busy_o) check("pass_timeout", int'(busy_o), 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic check_cell(input string name, input int x, input int y, input int req);
    check(name, int'(ram[y * COLUMNS + x]), req);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_ni = 1'b0; start_i = 1'b0; spawn_en_i = 1'b0; spawn_x_i = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (3) tick();
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_wr_en", int'(mem_wr_en_o), 0);
    check("rst_wr_addr", int'(mem_wr_addr_o), 0);
    check("rst_wr_data", int'(mem_wr_data_o), 0);
    check("rst_rd_addr", int'(mem_rd_addr_o), 0);
    reset_ni = 1'b1;
    clear_grid();

    // Empty grid: no writes, done 25 cycles after start; starts while busy and in DONE are ignored.
    push_done(25);
    pulse_start(1'b0, 0);
    repeat (5) tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    repeat (18) tick();
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("start_in_done_ignored", int'(busy_o), 0);
    tick();
    check("still_idle", int'(busy_o), 0);
    wait_idle();

    // Single grain falls one row per pass, then rests on the bottom row.
    load(1, 0, 1);
    push_wr(23, 5, 1); push_wr(24, 1, 0); push_done(29);
    pulse_start(1'b0, 0); wait_idle();
    check_cell("pass1_dst", 1, 1, 1); check_cell("pass1_src", 1, 0, 0);
    push_wr(15, 9, 1); push_wr(16, 5, 0); push_done(29);
    pulse_start(1'b0, 0); wait_idle();
    check_cell("pass2_dst", 1, 2, 1); check_cell("pass2_src", 1, 1, 0);
    push_wr(7, 13, 1); push_wr(8, 9, 0); push_done(29);
    pulse_start(1'b0, 0); wait_idle();
    check_cell("pass3_dst", 1, 3, 1); check_cell("pass3_src", 1, 2, 0);
    push_done(25);
    pulse_start(1'b0, 0); wait_idle();
    check_cell("pass4_rest", 1, 3, 1);

    // Blocked below, slides down-left on consecutive write cycles.
    clear_grid();
    load(1, 2, 1); load(1, 3, 1);
    push_wr(9, 12, 1); push_wr(10, 9, 0); push_done(31);
    pulse_start(1'b0, 0); wait_idle();
    check_cell("diag_dst", 0, 3, 1); check_cell("diag_src", 1, 2, 0);
    check_cell("diag_below", 1, 3, 1);

    // Left edge, fully blocked by sand and wall: no writes, 8 cycles for that cell.
    clear_grid();
    load(0, 2, 1); load(0, 3, 1); load(1, 3, 2);
    push_done(31);
    pulse_start(1'b0, 0); wait_idle();
    check_cell("blocked_stays", 0, 2, 1); check_cell("wall_kept", 1, 3, 2);

    // Spawn in range, out of range, and onto an occupied cell.
    clear_grid();
    push_wr(27, 2, 1); push_done(28);
    pulse_start(1'b1, 2); wait_idle();
    check_cell("spawn_cell", 2, 0, 1);
    clear_grid();
    push_done(25);
    pulse_start(1'b1, 5); wait_idle();
    check_cell("spawn_oob_col1", 1, 0, 0);
    load(3, 0, 2);
    push_done(27);
    pulse_start(1'b1, 3); wait_idle();
    check_cell("spawn_blocked", 3, 0, 2);

    // Reset in WR_DST aborts the pass; a later start runs a clean pass on the partial grid.
    clear_grid();
    load(1, 2, 1);
    push_wr(7, 13, 1);
    pulse_start(1'b0, 0);
    n = 0;
    while (!mem_wr_en_o && n < 60) begin
      tick();
      n++;
    end
    if (!mem_wr_en_o) check("reset_wr_seen", int'(mem_wr_en_o), 1);
    reset_ni = 1'b0;
    tick();
    check("abort_wr_en", int'(mem_wr_en_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_done", int'(done_o), 0);
    tick();
    reset_ni = 1'b1;
    tick();
    check("abort_drained", exp_q.size(), 0);
    check_cell("abort_dst", 1, 3, 1); check_cell("abort_src_kept", 1, 2, 1);
    push_wr(9, 12, 1); push_wr(10, 9, 0); push_done(31);
    pulse_start(1'b0, 0); wait_idle();
    check_cell("clean_dst", 0, 3, 1); check_cell("clean_src", 1, 2, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
